grid_host_port: RTL

//  Host-side endpoint of the gridcell array. Receives a byte-stream frame with

---
 rtl/grid_host_port_pkg.sv | 11 +
 rtl/grid_host_port_if.sv | 24 ++
 rtl/grid_host_port_tx_serializer.sv | 43 ++++
 rtl/grid_host_port.sv | 111 +++++++++++
 4 files changed

// File: rtl/grid_host_port_pkg.sv
// grid_pkg: shared states and constants for the gridcell host port
package grid_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_GET_ERR, S_GET_MIN, S_GET_CELL, S_SEED,
    S_RUN, S_SNAP, S_SEND_STAT, S_SEND_CELL
  } state_t;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int STAT_CONV_BIT = 7;
  localparam int STAT_TMO_BIT = 6;
  localparam int CELL_W = 8;
endpackage

// File: rtl/grid_host_port_if.sv
// grid_host_port_if: host byte streams plus the gridcell array control bus
interface grid_host_port_if import grid_pkg::*; #(parameter int NCELLS = 4);
  logic [7:0] din;
  logic din_valid;
  logic din_ready;
  logic [7:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic [CELL_W*NCELLS-1:0] cell_val;
  logic [7:0] err_tol;
  logic [7:0] min_tol;
  logic grid_reset;
  logic conv_all;
  logic [CELL_W*NCELLS-1:0] gc_val_all;
  logic busy;
  modport slave (
    input din, din_valid, dout_ready, conv_all, gc_val_all,
    output din_ready, dout, dout_valid, cell_val, err_tol, min_tol, grid_reset, busy
  );
  modport master (
    output din, din_valid, dout_ready, conv_all, gc_val_all,
    input din_ready, dout, dout_valid, cell_val, err_tol, min_tol, grid_reset, busy
  );
endinterface

// File: rtl/grid_host_port_tx_serializer.sv
// grid_tx_serializer: snapshots cell results and streams status then cell bytes
module grid_tx_serializer import grid_pkg::*; #(
  parameter int NCELLS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [7:0]               stat,
  input  logic [CELL_W*NCELLS-1:0] cells,
  input  logic                     ready,
  output logic [7:0]               dout,
  output logic                     valid,
  output logic                     last
);
  localparam int IW = $clog2(NCELLS + 1);
  logic [CELL_W*NCELLS-1:0] snap;
  logic [IW-1:0] idx;
  // idx 0 is the status byte; idx NCELLS is the final cell byte on the wire
  assign last = idx == IW'(NCELLS);
  // load presents the status byte at once; each accept advances to the next byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
      idx <= '0;
      dout <= '0;
      valid <= 1'b0;
    end else if (load) begin
      snap <= cells;
      idx <= '0;
      dout <= stat;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (last) begin
        idx <= '0;
        dout <= '0;
        valid <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
        dout <= snap[idx*CELL_W +: CELL_W];
      end
    end
  end
endmodule

// File: rtl/grid_host_port.sv
// grid_host_port: loads a frame into the gridcell array, runs it and returns results
module grid_host_port import grid_pkg::*; #(
  parameter int NCELLS = 4,
  parameter int MAX_CYC = 1024,
  parameter int CONV_HOLD = 2
) (
  input logic clk,
  input logic rst_n,
  grid_host_port_if.slave bus
);
  localparam int IW = $clog2(NCELLS + 1);
  localparam logic [15:0] LAST_CYC = 16'(MAX_CYC - 1);
  localparam logic [15:0] HOLD_N = 16'(CONV_HOLD);
  state_t state;
  logic [IW-1:0] idx;
  logic [15:0] cyc, hold, hold_nxt;
  logic conv, tmo, acc_in, tx_last;
  logic [7:0] stat;
  assign acc_in = bus.din_valid && bus.din_ready;
  assign hold_nxt = bus.conv_all ? hold + 16'd1 : 16'd0;
  // status byte carries the run outcome flags
  always_comb begin
    stat = '0;
    stat[STAT_CONV_BIT] = conv;
    stat[STAT_TMO_BIT] = tmo;
  end
  // frame capture, seed/run sequencing and result hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bus.din_ready <= 1'b1;
      bus.cell_val <= '0;
      bus.err_tol <= '0;
      bus.min_tol <= '0;
      bus.grid_reset <= 1'b1;
      bus.busy <= 1'b0;
      idx <= '0;
      cyc <= '0;
      hold <= '0;
      conv <= 1'b0;
      tmo <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (acc_in && bus.din == HDR_BYTE) begin
          state <= S_GET_ERR;
          bus.busy <= 1'b1;
          conv <= 1'b0;
          tmo <= 1'b0;
        end
        S_GET_ERR: if (acc_in) begin
          bus.err_tol <= bus.din;
          state <= S_GET_MIN;
        end
        S_GET_MIN: if (acc_in) begin
          bus.min_tol <= bus.din;
          idx <= '0;
          state <= S_GET_CELL;
        end
        S_GET_CELL: if (acc_in) begin
          bus.cell_val[idx*CELL_W +: CELL_W] <= bus.din;
          idx <= idx + 1'b1;
          if (idx == IW'(NCELLS - 1)) begin
            bus.din_ready <= 1'b0;
            cyc <= '0;
            state <= S_SEED;
          end
        end
        S_SEED: begin
          cyc <= cyc + 16'd1;
          if (cyc == 16'd1) begin
            bus.grid_reset <= 1'b0;
            cyc <= '0;
            hold <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          cyc <= cyc + 16'd1;
          hold <= hold_nxt;
          if (hold_nxt == HOLD_N) begin
            conv <= 1'b1;
            state <= S_SNAP;
          end else if (cyc == LAST_CYC) begin
            tmo <= 1'b1;
            state <= S_SNAP;
          end
        end
        S_SNAP: state <= S_SEND_STAT;
        S_SEND_STAT: if (bus.dout_valid && bus.dout_ready) state <= S_SEND_CELL;
        S_SEND_CELL: if (bus.dout_valid && bus.dout_ready && tx_last) begin
          bus.busy <= 1'b0;
          bus.grid_reset <= 1'b1;
          bus.din_ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  grid_tx_serializer #(.NCELLS(NCELLS)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == S_SNAP),
    .stat(stat),
    .cells(bus.gc_val_all),
    .ready(bus.dout_ready),
    .dout(bus.dout),
    .valid(bus.dout_valid),
    .last(tx_last)
  );
endmodule
